// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the keypad-to-divider sequencer.
// Holds the FSM state encoding, error codes and default widths.
package div_ctrl_pkg;

    localparam int OP_W_DEF        = 8;
    localparam int Q_W_DEF         = 7;
    localparam int TIMEOUT_CYC_DEF = 1024;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DIV0 = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [3:0] {
        S_GET_A_HI = 4'd0,
        S_GET_A_LO = 4'd1,
        S_GET_B_HI = 4'd2,
        S_GET_B_LO = 4'd3,
        S_CHECK    = 4'd4,
        S_START    = 4'd5,
        S_WAIT     = 4'd6,
        S_SHOW     = 4'd7,
        S_ERR      = 4'd8
    } state_e;

endpackage

// File: rtl/div_operand_entry.sv
// Nibble-wise operand register for A and B (high nibble first).
// The phase counter names the nibble the next key will land in.
module div_operand_entry
    import div_ctrl_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            restart_i,
    input  logic            load_i,
    input  logic [3:0]      key_i,
    output logic [OP_W-1:0] op_a_o,
    output logic [OP_W-1:0] op_b_o,
    output logic [1:0]      phase_o
);

    localparam int LO_W = OP_W - 4;

    logic [OP_W-1:0] op_a_q, op_a_d;
    logic [OP_W-1:0] op_b_q, op_b_d;
    logic [1:0]      phase_q, phase_d;

    // Next operand/phase: clear beats restart, restart beats a normal nibble load
    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        phase_d = phase_q;
        if (clr_i) begin
            op_a_d  = {OP_W{1'b0}};
            op_b_d  = {OP_W{1'b0}};
            phase_d = 2'd0;
        end else if (restart_i) begin
            op_a_d  = {key_i, {LO_W{1'b0}}};
            op_b_d  = {OP_W{1'b0}};
            phase_d = 2'd1;
        end else if (load_i) begin
            case (phase_q)
                2'd0:    op_a_d[OP_W-1 -: 4] = key_i;
                2'd1:    op_a_d[3:0]         = key_i;
                2'd2:    op_b_d[OP_W-1 -: 4] = key_i;
                2'd3:    op_b_d[3:0]         = key_i;
                default: op_a_d              = op_a_q;
            endcase
            phase_d = phase_q + 2'd1;
        end else begin
            phase_d = phase_q;
        end
    end

    // Operand and phase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= {OP_W{1'b0}};
            op_b_q  <= {OP_W{1'b0}};
            phase_q <= 2'd0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            phase_q <= phase_d;
        end
    end

    assign op_a_o  = op_a_q;
    assign op_b_o  = op_b_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer between keypad scanner and 8-bit divider: operand entry, pre-checks,
// start/wait-with-timeout handshake and result/error latch for the display.
module div_seq_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int Q_W         = Q_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    input  logic            clr_req,
    input  logic            div_done,
    input  logic [Q_W-1:0]  div_q,
    input  logic [Q_W-1:0]  div_r,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            div_start,
    output logic [Q_W-1:0]  res_q,
    output logic [Q_W-1:0]  res_r,
    output logic            res_valid,
    output logic [1:0]      err_code,
    output logic            busy,
    output logic [1:0]      entry_phase
);

    localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Quotient cannot fit in Q_W bits when a >= b * 2^Q_W
    function automatic logic quot_ovf(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [OP_W+Q_W-1:0] a_ext;
        logic [OP_W+Q_W-1:0] b_ext;
        a_ext = {{Q_W{1'b0}}, a};
        b_ext = {b, {Q_W{1'b0}}};
        return (a_ext >= b_ext);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [Q_W-1:0]   rem_q, rem_d;
    logic             div_start_q;
    logic             busy_q;
    logic             res_valid_q;
    logic             ent_clr_s;
    logic             ent_load_s;
    logic             ent_restart_s;
    logic [OP_W-1:0]  op_a_s;
    logic [OP_W-1:0]  op_b_s;
    logic [1:0]       phase_s;

    div_operand_entry #(
        .OP_W (OP_W)
    ) u_entry (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ent_clr_s),
        .restart_i (ent_restart_s),
        .load_i    (ent_load_s),
        .key_i     (key_code),
        .op_a_o    (op_a_s),
        .op_b_o    (op_b_s),
        .phase_o   (phase_s)
    );

    // Next-state, checks, timeout counting and result capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        ent_clr_s     = 1'b0;
        ent_load_s    = 1'b0;
        ent_restart_s = 1'b0;
        if (clr_req) begin
            state_d   = S_GET_A_HI;
            cnt_d     = {CNT_W{1'b0}};
            err_d     = ERR_NONE;
            quo_d     = {Q_W{1'b0}};
            rem_d     = {Q_W{1'b0}};
            ent_clr_s = 1'b1;
        end else begin
            case (state_q)
                S_GET_A_HI, S_GET_A_LO, S_GET_B_HI: begin
                    if (key_valid) begin
                        ent_load_s = 1'b1;
                        state_d    = state_e'(state_q + 4'd1);
                    end else begin
                        state_d = state_q;
                    end
                end
                S_GET_B_LO: begin
                    if (key_valid) begin
                        ent_load_s = 1'b1;
                        state_d    = S_CHECK;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_CHECK: begin
                    if (op_b_s == {OP_W{1'b0}}) begin
                        err_d   = ERR_DIV0;
                        state_d = S_ERR;
                    end else if (quot_ovf(op_a_s, op_b_s)) begin
                        err_d   = ERR_OVF;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // done on the final timeout cycle still counts as success
                    if (div_done) begin
                        quo_d   = div_q;
                        rem_d   = div_r;
                        state_d = S_SHOW;
                    end else if (cnt_q == CNT_LAST) begin
                        err_d   = ERR_TMO;
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SHOW, S_ERR: begin
                    if (key_valid) begin
                        ent_restart_s = 1'b1;
                        err_d         = ERR_NONE;
                        state_d       = S_GET_A_LO;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = S_GET_A_HI;
                end
            endcase
        end
    end

    // State and registered outputs; flags are decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_GET_A_HI;
            cnt_q       <= {CNT_W{1'b0}};
            err_q       <= ERR_NONE;
            quo_q       <= {Q_W{1'b0}};
            rem_q       <= {Q_W{1'b0}};
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div_start_q <= (state_d == S_START);
            busy_q      <= (state_d == S_START) || (state_d == S_WAIT);
            res_valid_q <= (state_d == S_SHOW);
        end
    end

    assign op_a        = op_a_s;
    assign op_b        = op_b_s;
    assign entry_phase = phase_s;
    assign div_start   = div_start_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign err_code    = err_q;
    assign res_q       = quo_q;
    assign res_r       = rem_q;

endmodule
